// File: rtl/parity_check_pipe_if.sv
// Bundle for the parity checker: word input, clear strobe and check results.
// The master modport is the word source and status consumer. The slave modport is the checker.
interface parity_check_pipe_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_par;
    logic             clr_cnt;
    logic             out_valid;
    logic             out_err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_data, in_par, clr_cnt,
        input  out_valid, out_err, err_sticky, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_par, clr_cnt,
        output out_valid, out_err, err_sticky, err_cnt
    );
endinterface

// File: rtl/parity_check_pipe.sv
// Pipelined parity checker: a registered 6-input XOR tree over {par, data}, a valid pipe
// running alongside it, a compare stage, and a sticky error flag with a saturating error count.
module parity_check_pipe #(
    parameter int WIDTH = 64,
    parameter bit ODD   = 1'b0,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst,
    parity_check_pipe_if.slave bus
);
    function automatic int ceil6(input int n);
        return (n + 5) / 6;
    endfunction

    function automatic int tree_depth(input int n);
        int m = n;
        int d = 1;
        while (m > 6) begin
            m = ceil6(m);
            d++;
        end
        return d;
    endfunction

    // Input width of tree level k.
    function automatic int level_width(input int n0, input int k);
        int n = n0;
        for (int i = 0; i < k; i++) n = ceil6(n);
        return n;
    endfunction

    // Bit offset of level k's outputs inside the flattened tree register.
    function automatic int level_off(input int n0, input int k);
        int o = 0;
        for (int i = 0; i < k; i++) o += level_width(n0, i + 1);
        return o;
    endfunction

    localparam int N0    = WIDTH + 1;
    localparam int DEPTH = tree_depth(N0);
    localparam int TOTAL = level_off(N0, DEPTH);

    logic [N0-1:0]    vec;
    logic [TOTAL-1:0] tree_d, tree_q;
    logic [DEPTH-1:0] vld_pipe_d, vld_pipe_q;
    logic             out_valid_d, out_valid_q;
    logic             out_err_d, out_err_q;
    logic             err_sticky_d, err_sticky_q;
    logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

    assign vec = {bus.in_par, bus.in_data};

    for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
        localparam int NI  = level_width(N0, k);
        localparam int NO  = ceil6(NI);
        localparam int PW  = 6 * NO;
        localparam int OFF = level_off(N0, k);

        logic [NI-1:0] src;
        logic [PW-1:0] pad;

        if (k == 0) begin : g_src
            assign src = vec;
        end else begin : g_src
            assign src = tree_q[level_off(N0, k - 1) +: NI];
        end

        assign pad = PW'(src);

        for (genvar j = 0; j < NO; j++) begin : g_xor
            assign tree_d[OFF + j] = ^pad[6*j +: 6];
        end
    end

    // NOTE: tree data is qualified by the valid pipe, so it needs no reset; only control state is reset.
    always_ff @(posedge clk) begin
        tree_q <= tree_d;
    end

    // NOTE: every signal assigned here gets a default first, so no latches are inferred.
    always_comb begin
        vld_pipe_d[0] = bus.in_valid;
        for (int i = 1; i < DEPTH; i++) vld_pipe_d[i] = vld_pipe_q[i-1];

        out_valid_d = vld_pipe_q[DEPTH-1];
        out_err_d   = vld_pipe_q[DEPTH-1] & (tree_q[TOTAL-1] ^ ODD);

        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (bus.clr_cnt) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end else if (out_err_q) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: reset is in the sensitivity list, so all outputs clear without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q   <= '0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            vld_pipe_q   <= vld_pipe_d;
            out_valid_q  <= out_valid_d;
            out_err_q    <= out_err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_err    = out_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: doc/parity_check_pipe.md
# parity_check_pipe

Pipelined even/odd parity checker for wide data words carrying one parity bit. It sits downstream of the word source and feeds error status to the link/status logic. It reduces data plus parity through a registered 6-input-per-level XOR tree, carries a valid bit alongside the tree, and flags each checked word. It also keeps a sticky error flag and a saturating error counter.

## Interface
- WIDTH, 64, data word width in bits; legal range 1..1024.
- ODD, 0, parity sense: 0 = even parity (XOR of data and par must be 0), 1 = odd parity (XOR must be 1).
- CNT_W, 16, error counter width; legal range 1..32.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  qualifies in_data/in_par this cycle; no backpressure, accepted every cycle.
- in_data  in  WIDTH  data word.
- in_par  in  1  transmitted parity bit for in_data.
- clr_cnt  in  1  synchronous clear of err_cnt and err_sticky.
- out_valid  out  1  a checked result is presented this cycle.
- out_err  out  1  parity mismatch for the presented word; forced 0 when out_valid=0.
- err_sticky  out  1  set by any out_err; held until clr_cnt or rst.
- err_cnt  out  CNT_W  count of out_err pulses, saturating at all-ones.

## Operation
- Reduced vector is V = {in_par, in_data}, width N0 = WIDTH+1.
- Tree level k:
  - Zero-pad the current vector to a multiple of 6.
  - XOR each 6-bit group into one registered bit, giving Nk+1 = ceil(Nk/6) bits.
  - Repeat while the vector is wider than 6 bits.
  - The final level registers the XOR of at most 6 bits.
- Tree depth: D(n) = 1 if n <= 6, else 1 + D(ceil(n/6)). Examples: D(65)=3; D(7)=2; D(2)=1.
- Compare stage: out_err <= valid_pipe_last & (tree_out ^ ODD). out_valid <= valid_pipe_last.
- Tree data registers have no reset; tree contents are don't-care when not qualified.
- Valid pipe: D shift stages, reset to 0, shifting every cycle.
- Error accounting uses the registered out_err, one cycle after it is presented:
  - If clr_cnt=1: err_cnt <= 0 and err_sticky <= 0. Clear has priority; an error presented in the same cycle is discarded.
  - Else if out_err=1: err_sticky <= 1, and err_cnt <= err_cnt+1 unless err_cnt is all-ones, in which case it holds.
- Results leave in acceptance order, one per accepted word, with no drops or merges. Back-to-back input at full rate is supported.

## Timing
- Latency is LAT = D(WIDTH+1) + 1 cycles from in_valid sampled high to out_valid high. WIDTH=64 gives LAT=4; WIDTH=5 gives LAT=2.
- err_sticky and err_cnt reflect an out_err one cycle after it is presented (LAT+1 from input).
- Reset values: out_valid=0, out_err=0, err_sticky=0, err_cnt=0, valid pipe all 0.
- Reset mid-operation:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - In-flight words are flushed and never produce out_valid.
  - After rst deasserts, the first out_valid corresponds to the first in_valid sampled after release, LAT cycles later.
- in_valid=0 cycles produce bubbles: out_valid=0 and out_err=0 at the matching output cycle.
- With WIDTH+1 <= 6, the tree is a single registered XOR of all bits.

## Test plan
- WIDTH=64, ODD=0: in_data=0, in_par=0 for one cycle at T → out_valid=1, out_err=0 at T+4; err_cnt stays 0.
- WIDTH=64, ODD=0: in_data=64'h1, in_par=0 at T → out_err=1 at T+4; at T+5 err_sticky=1 and err_cnt=1. Repeat with ODD=1, in_par=0, in_data=0 → same error response.
- Back-to-back stream of 8 words, one per cycle, every other word with a flipped parity bit (pattern starting good) → out_valid high for 8 consecutive cycles starting at T+4; out_err pattern 0,1,0,1,0,1,0,1; final err_cnt=4.
- CNT_W=4: 20 consecutive bad words → err_cnt climbs to 15 and holds at 15; err_sticky=1. Then clr_cnt pulsed in the same cycle an out_err=1 is presented → err_cnt=0, err_sticky=0 next cycle.
- rst asserted for one cycle while 3 words are in flight, asynchronous to the clock edge → out_valid/out_err/err_cnt/err_sticky go to 0 immediately; none of the 3 words emerge. A word sent 2 cycles after release appears exactly LAT cycles after its acceptance.
- WIDTH=5 (LAT=2) and WIDTH=35 (D(36)=2, LAT=3): randomized 1000-word stream with random in_valid gaps → out_valid/out_err match a reference parity model, delayed by LAT, cycle-exact.
